// File: rtl/audio_dac_serializer_pkg.sv
// Shared sample types for the codec audio path (DAC serializer, ADC deserializer).
package audio_pkg;

    localparam int SAMPLE_W = 24;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        LEFT,
        RIGHT
    } tx_state_t;

endpackage

// File: rtl/audio_dac_serializer_sample_fifo.sv
// Single-clock FIFO of stereo sample pairs with occupancy count.
// Latency: push visible at pop_dat_o the cycle after the push edge; pop data is read combinationally.
// Backpressure: full_o high blocks pushes; pushes while full and pops while empty are ignored.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  stereo_t                  push_dat_i,
    output logic                     full_o,
    input  logic                     pop_i,
    output stereo_t                  pop_dat_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    stereo_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// Buffers stereo pairs and shifts them MSB-first, left-justified, onto the codec DAC pin.
// Latency: AUD_DACDAT follows a BCLK/LRCK pin change by SYNC_STAGES+1 CLOCK_50 edges.
// Backpressure: write_ready = FIFO not full (low during reset); pushes while not ready are dropped.
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          write,
    input  logic [DATA_WIDTH-1:0]         writedata_left,
    input  logic [DATA_WIDTH-1:0]         writedata_right,
    output logic                          write_ready,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_DACLRCK,
    output logic                          AUD_DACDAT,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int CNT_W = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_W);

    logic [SYNC_STAGES-1:0] bclk_sync_q, lr_sync_q;
    logic                   bclk_hist_q, lr_hist_q;
    logic [SYNC_STAGES:0]   prime_q;
    logic                   edges_ok, bclk_fall, lr_rise, lr_fall;

    tx_state_t          state_q, state_d;
    sample_t            shreg_q, shreg_d;
    sample_t            hold_r_q, hold_r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               underrun_q, underrun_d;

    stereo_t            wr_pair, fifo_dat;
    logic               fifo_full, fifo_empty, fifo_pop;

    assign wr_pair     = {writedata_left, writedata_right};
    assign write_ready = ~fifo_full & ~reset;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (CLOCK_50),
        .rst_i      (reset),
        .push_i     (write & write_ready),
        .push_dat_i (wr_pair),
        .full_o     (fifo_full),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .empty_o    (fifo_empty),
        .count_o    (fill_level)
    );

    // Edges are only trusted once the history flop holds a real pin sample, so a pin
    // already high at reset release is not mistaken for a rising edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            bclk_hist_q <= 1'b0;
            lr_hist_q   <= 1'b0;
            prime_q     <= '0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
            lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], AUD_DACLRCK};
            bclk_hist_q <= bclk_sync_q[SYNC_STAGES-1];
            lr_hist_q   <= lr_sync_q[SYNC_STAGES-1];
            prime_q     <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign edges_ok  = prime_q[SYNC_STAGES];
    assign bclk_fall = edges_ok &  bclk_hist_q & ~bclk_sync_q[SYNC_STAGES-1];
    assign lr_rise   = edges_ok & ~lr_hist_q   &  lr_sync_q[SYNC_STAGES-1];
    assign lr_fall   = edges_ok &  lr_hist_q   & ~lr_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        hold_r_d   = hold_r_q;
        cnt_d      = cnt_q;
        underrun_d = underrun_q;
        fifo_pop   = 1'b0;
        // LRCK edges take priority over a coincident BCLK fall, which is consumed.
        if (lr_rise) begin
            state_d = LEFT;
            cnt_d   = '0;
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                shreg_d  = fifo_dat.l;
                hold_r_d = fifo_dat.r;
            end else begin
                shreg_d    = '0;
                hold_r_d   = '0;
                underrun_d = 1'b1;
            end
        end else begin
            case (state_q)
                LEFT, RIGHT: begin
                    if (lr_fall) begin
                        state_d = RIGHT;
                        shreg_d = hold_r_q;
                        cnt_d   = '0;
                    end else if (bclk_fall && (cnt_q < CNT_MAX)) begin
                        shreg_d = {shreg_q[SAMPLE_W-2:0], 1'b0};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = WAIT_SYNC;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= WAIT_SYNC;
            shreg_q    <= '0;
            hold_r_q   <= '0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            hold_r_q   <= hold_r_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
        end
    end

    // Zeros shift in behind the sample, so the pad bits of a wide slot are 0.
    assign AUD_DACDAT = shreg_q[SAMPLE_W-1];
    assign underrun   = underrun_q;

endmodule
